basic_producer: RTL and testbench
=================================

BASIC_PRODUCER -- requirements
Module: basic_producer

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: maximum words emitted per accepted command (1..2^16).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_in, input, 32 (signed integer): requested burst length.
REQ-005 SHALL have port cmd_in_sync, input, 1: environment offers cmd_in this cycle.
REQ-006 SHALL have port cmd_in_notify, output, 1: block ready to read cmd_in.
REQ-007 SHALL have port b_out, output, 32 (signed integer): data word offered.
REQ-008 SHALL have port b_out_sync, input, 1: environment accepts b_out this cycle.
REQ-009 SHALL have port b_out_notify, output, 1: b_out is valid and offered.

Function
REQ-010 SHALL implement two sections: section_idle (read command) and section_send (emit burst).
REQ-011 Command transfer SHALL occur on a rising edge where cmd_in_notify=1 and cmd_in_sync=1; output transfer on an edge where b_out_notify=1 and b_out_sync=1.
REQ-012 All outputs SHALL be registered; no combinational path from any *_sync input to any output.
REQ-013 In section_idle: cmd_in_notify=1, b_out_notify=0.
REQ-014 On a command transfer with cmd_in<=0: command discarded, remain in section_idle, cmd_in_notify stays 1.
REQ-015 On a command transfer with cmd_in>0: remaining := min(cmd_in, MAX_BURST); go to section_send; after the same edge cmd_in_notify=0, b_out_notify=1, b_out=x_signal (one-edge latency).
REQ-016 x_signal SHALL be an internal 32-bit counter, reset 0, persisting across bursts.
REQ-017 In section_send, b_out and b_out_notify SHALL hold stable on every edge without an output transfer (b_out_sync=0 stalls indefinitely).
REQ-018 On each output transfer: x_signal := x_signal+1 modulo 2^32 (0x7FFFFFFF -> 0x80000000, 0xFFFFFFFF -> 0); remaining := remaining-1.
REQ-019 If remaining>1 at an output transfer: stay in section_send, b_out := new x_signal, b_out_notify stays 1 (back-to-back, one word per cycle).
REQ-020 If remaining=1 at an output transfer: go to section_idle; after that edge b_out_notify=0, cmd_in_notify=1; b_out holds last value.
REQ-021 cmd_in_sync SHALL be ignored in section_send; b_out_sync SHALL be ignored in section_idle.
REQ-022 cmd_in_notify and b_out_notify SHALL never both be 1.

Reset
REQ-023 While rst=1, asynchronously: section=section_idle, x_signal=0, remaining=0, b_out=0, b_out_notify=0, cmd_in_notify=1.
REQ-024 Reset during section_send SHALL abort the burst; no further words offered; x_signal restarts at 0.
REQ-025 First command transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-026 Reset, cmd_in=3 with sync one cycle, b_out_sync held 1 -> b_out 0,1,2 on three consecutive edges, then cmd_in_notify=1; second cmd_in=2 -> b_out 3,4.
REQ-027 cmd_in=0 then cmd_in=-5 offered -> no b_out_notify, cmd_in_notify stays 1, x_signal unchanged.
REQ-028 cmd_in=100, MAX_BURST=16 -> exactly 16 words (0..15), then idle.
REQ-029 cmd_in=2, b_out_sync toggled 0,0,1,0,1 -> b_out held 0 for three cycles, then 1; exactly two transfers; no duplicates or drops.
REQ-030 Preload x_signal to 0xFFFFFFFE via 0xFFFFFFFE words of traffic (or force), cmd_in=3 -> b_out 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-031 rst asserted after second word of cmd_in=5 -> outputs immediately at reset values; next cmd_in=1 -> b_out=0.

Source files
------------

// File: rtl/basic_producer.sv
// Command-driven burst producer: accepts a signed burst length, then emits
// up to MAX_BURST consecutive values of a persistent 32-bit counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | section_idle: cmd_in_notify=1, waiting for a positive command
// ST_SEND | section_send: b_out_notify=1, word held until b_out_sync
module basic_producer #(
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] cmd_in,
  input  logic               cmd_in_sync,
  output logic               cmd_in_notify,
  output logic signed [31:0] b_out,
  input  logic               b_out_sync,
  output logic               b_out_notify
);

  localparam int REM_W = $clog2(MAX_BURST + 1);
  localparam logic signed [31:0] MAX_S = 32'(MAX_BURST);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_signal_q, x_signal_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic signed [31:0] b_out_q, b_out_d;
  logic               b_notify_q, b_notify_d;
  logic               cmd_notify_q, cmd_notify_d;
  logic [REM_W-1:0]   burst_len;

  // Clamp is only meaningful for positive commands; negatives never reach rem_d.
  assign burst_len = (cmd_in > MAX_S) ? MAX_S[REM_W-1:0] : cmd_in[REM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_signal_q   <= '0;
      rem_q        <= '0;
      b_out_q      <= '0;
      b_notify_q   <= 1'b0;
      cmd_notify_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_signal_q   <= x_signal_d;
      rem_q        <= rem_d;
      b_out_q      <= b_out_d;
      b_notify_q   <= b_notify_d;
      cmd_notify_q <= cmd_notify_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_signal_d   = x_signal_q;
    rem_d        = rem_q;
    b_out_d      = b_out_q;
    b_notify_d   = b_notify_q;
    cmd_notify_d = cmd_notify_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_in_sync && (cmd_in > 32'sd0)) begin
          state_d      = ST_SEND;
          rem_d        = burst_len;
          b_out_d      = $signed(x_signal_q);
          b_notify_d   = 1'b1;
          cmd_notify_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (b_out_sync) begin
          x_signal_d = x_signal_q + 32'd1;
          rem_d      = rem_q - REM_W'(1);
          if (rem_q > REM_W'(1)) begin
            b_out_d = $signed(x_signal_q + 32'd1);
          end else begin
            // Last word taken: b_out keeps its final value while idle.
            state_d      = ST_IDLE;
            b_notify_d   = 1'b0;
            cmd_notify_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_in_notify = cmd_notify_q;
  assign b_out_notify  = b_notify_q;
  assign b_out         = b_out_q;

endmodule

// File: tb/tb_basic_producer.sv
// Scoreboard bench for basic_producer: directed commands push hand-computed
// words; a negedge monitor pops and compares on every output transfer.
module tb_basic_producer;

  logic               clk;
  logic               rst;
  logic signed [31:0] cmd_in;
  logic               cmd_in_sync;
  logic               cmd_in_notify;
  logic signed [31:0] b_out;
  logic               b_out_sync;
  logic               b_out_notify;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfers  = 0;
  logic [31:0] exp_q[$];
  logic        stall_pending = 1'b0;
  logic [31:0] stall_val;

  basic_producer #(.MAX_BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_in       (cmd_in),
    .cmd_in_sync  (cmd_in_sync),
    .cmd_in_notify(cmd_in_notify),
    .b_out        (b_out),
    .b_out_sync   (b_out_sync),
    .b_out_notify (b_out_notify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a transfer happens on the posedge following a negedge where
  // notify and sync are both high.
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      check("notify_exclusive", {31'd0, cmd_in_notify & b_out_notify}, 32'd0);
      if (b_out_notify) begin
        if (stall_pending) check("stall_hold", b_out, stall_val);
        if (b_out_sync) begin
          stall_pending = 1'b0;
          n_xfers++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", b_out, 32'hDEAD_BEEF);
          end else begin
            check("b_out_word", b_out, exp_q.pop_front());
          end
        end else begin
          stall_pending = 1'b1;
          stall_val     = b_out;
        end
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_notify", {31'd0, cmd_in_notify}, 32'd1);
    check("rst_b_notify", {31'd0, b_out_notify}, 32'd0);
    check("rst_b_out", b_out, 32'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic signed [31:0] v);
    int i = 0;
    while (!cmd_in_notify && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    check("cmd_ready_timeout", {31'd0, cmd_in_notify}, 32'd1);
    cmd_in      = v;
    cmd_in_sync = 1'b1;
    @(posedge clk); #1;
    cmd_in_sync = 1'b0;
    cmd_in      = 32'sd0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (!(exp_q.size() == 0 && cmd_in_notify && !b_out_notify) && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && cmd_in_notify && !b_out_notify)}, 32'd1);
  endtask

  task automatic check_no_burst(input string name);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check(name, {30'd0, b_out_notify, cmd_in_notify}, 32'd1);
    end
  endtask

  initial begin
    int x0;
    rst         = 1'b1;
    cmd_in      = 32'sd0;
    cmd_in_sync = 1'b0;
    b_out_sync  = 1'b1;
    #12;
    do_reset();

    // Basic burst then a second one continuing the counter.
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    send_cmd(32'sd3);
    wait_drain("drain_cmd3");
    exp_q.push_back(32'd3); exp_q.push_back(32'd4);
    send_cmd(32'sd2);
    wait_drain("drain_cmd2");

    // Non-positive commands are discarded; the counter must not move.
    send_cmd(32'sd0);
    check_no_burst("cmd0_ignored");
    send_cmd(-32'sd5);
    check_no_burst("cmdneg_ignored");
    exp_q.push_back(32'd5);
    send_cmd(32'sd1);
    wait_drain("drain_cmd1");

    // Oversized command clamps to MAX_BURST words.
    do_reset();
    x0 = n_xfers;
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k));
    send_cmd(32'sd100);
    wait_drain("drain_cmd100");
    check("cmd100_count", 32'(n_xfers - x0), 32'd16);

    // Stalls: sync pattern 0,0,1,0,1 after the command edge.
    x0 = n_xfers;
    b_out_sync = 1'b0;
    exp_q.push_back(32'd16); exp_q.push_back(32'd17);
    send_cmd(32'sd2);
    check("stall_first_word", b_out, 32'd16);
    b_out_sync = 1'b0; @(posedge clk); #1;
    b_out_sync = 1'b0; @(posedge clk); #1;
    check("stall_still_first", b_out, 32'd16);
    b_out_sync = 1'b1; @(posedge clk); #1;
    check("stall_second_word", b_out, 32'd17);
    b_out_sync = 1'b0; @(posedge clk); #1;
    b_out_sync = 1'b1; @(posedge clk); #1;
    check("stall_idle_after", {31'd0, cmd_in_notify}, 32'd1);
    b_out_sync = 1'b1;
    wait_drain("drain_stall");
    check("stall_count", 32'(n_xfers - x0), 32'd2);

    // Counter wraparound from a preloaded value.
    force dut.x_signal_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.x_signal_q;
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    send_cmd(32'sd3);
    wait_drain("drain_wrap");

    // Reset in the middle of a burst aborts it.
    do_reset();
    x0 = n_xfers;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    send_cmd(32'sd5);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_b_notify", {31'd0, b_out_notify}, 32'd0);
    check("abort_cmd_notify", {31'd0, cmd_in_notify}, 32'd1);
    check("abort_b_out", b_out, 32'd0);
    check("abort_count", 32'(n_xfers - x0), 32'd2);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(32'd0);
    send_cmd(32'sd1);
    wait_drain("drain_after_abort");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
